// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer.
// Walks a register list lowest-first, one memory transfer per register,
// generates word addresses for the IA/IB/DA/DB modes and optionally
// writes the final address back to the base register.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int REGS   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_load,
    input  logic [REGS-1:0]          reg_list,
    input  logic [$clog2(REGS)-1:0]  base_reg,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic                     up,
    input  logic                     pre,
    input  logic                     writeback,
    output logic [$clog2(REGS)-1:0]  rf_read_num,
    input  logic [ADDR_W-1:0]        rf_read_data,
    output logic [$clog2(REGS)-1:0]  rf_write_reg,
    output logic [ADDR_W-1:0]        rf_write_data,
    output logic                     rf_regwrite,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [ADDR_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [ADDR_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic                     done
);

    localparam int RW = $clog2(REGS);
    localparam int CW = $clog2(REGS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_LOAD_WR,
        S_WB,
        S_DONE
    } state_t;

    state_t            state;
    logic [REGS-1:0]   list_r;
    logic [REGS-1:0]   list_next;
    logic              is_load_r;
    logic              up_r;
    logic              pre_r;
    logic              wb_en_r;
    logic [RW-1:0]     base_reg_r;
    logic [RW-1:0]     cur;
    logic [RW-1:0]     cur_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] final_r;
    logic [ADDR_W-1:0] rdata_r;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] final_addr;

    function automatic logic [CW-1:0] popcount(input logic [REGS-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < REGS; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Remaining list with its lowest set bit removed (the register just transferred).
    assign list_next = list_r & (list_r - REGS'(1));

    // Lowest set bit of the remaining list selects the register for this transfer.
    always_comb begin
        cur = '0;
        for (int i = REGS - 1; i >= 0; i--) begin
            if (list_r[i]) begin
                cur = RW'(i);
            end
        end
    end

    // Lowest and final addresses; the lowest register always lands at the lowest address.
    always_comb begin
        count = popcount(list_r);
        span  = ADDR_W'(count) << 2;
        if (up_r) begin
            final_addr = base_r + span;
            start_addr = pre_r ? base_r + ADDR_W'(4) : base_r;
        end else begin
            final_addr = base_r - span;
            start_addr = pre_r ? base_r - span : base_r - span + ADDR_W'(4);
        end
    end

    // Control: state sequencing and the remaining register list.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            list_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        list_r <= reg_list;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    state <= (list_r == '0) ? S_DONE : S_XFER;
                end
                S_XFER: begin
                    if (mem_ack) begin
                        list_r <= list_next;
                        if (is_load_r) begin
                            state <= S_LOAD_WR;
                        end else if (list_next == '0) begin
                            state <= S_WB;
                        end
                    end
                end
                S_LOAD_WR: begin
                    state <= (list_r == '0) ? S_WB : S_XFER;
                end
                S_WB:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: command capture, address stepping and load-data capture.
    always_ff @(posedge clock) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    is_load_r  <= is_load;
                    up_r       <= up;
                    pre_r      <= pre;
                    base_reg_r <= base_reg;
                    base_r     <= base_addr;
                    // A load that includes the base register keeps the loaded value.
                    wb_en_r    <= writeback & ~(is_load & reg_list[base_reg]);
                end
            end
            S_SETUP: begin
                addr_r  <= start_addr;
                final_r <= final_addr;
            end
            S_XFER: begin
                if (mem_ack) begin
                    addr_r  <= addr_r + ADDR_W'(4);
                    cur_r   <= cur;
                    rdata_r <= mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Output decode from the registered state; everything idles at zero.
    always_comb begin
        busy          = (state == S_SETUP) || (state == S_XFER) ||
                        (state == S_LOAD_WR) || (state == S_WB);
        done          = (state == S_DONE);
        mem_req       = (state == S_XFER);
        mem_we        = (state == S_XFER) && !is_load_r;
        mem_addr      = (state == S_XFER) ? addr_r : '0;
        rf_read_num   = mem_we ? cur : '0;
        mem_wdata     = mem_we ? rf_read_data : '0;
        rf_regwrite   = 1'b0;
        rf_write_reg  = '0;
        rf_write_data = '0;
        if (state == S_LOAD_WR) begin
            rf_regwrite   = 1'b1;
            rf_write_reg  = cur_r;
            rf_write_data = rdata_r;
        end else if (state == S_WB && wb_en_r) begin
            rf_regwrite   = 1'b1;
            rf_write_reg  = base_reg_r;
            rf_write_data = final_r;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Testbench for ldm_stm_sequencer: directed scenarios plus randomized
// commands checked against a list/arithmetic reference model.
module tb_ldm_stm_sequencer;

    logic        clock, reset, start, is_load, up, pre, writeback, mem_ack;
    logic [15:0] reg_list;
    logic [3:0]  base_reg, rf_read_num, rf_write_reg;
    logic [31:0] base_addr, rf_read_data, rf_write_data, mem_addr, mem_wdata, mem_rdata;
    logic        rf_regwrite, mem_req, mem_we, busy, done;

    logic [31:0] rf [16];

    int vectors = 0;
    int miscompares = 0;

    // Observations from the last command
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$], rfw_data_q[$];
    logic [3:0]  rfw_reg_q[$];
    int done_cyc, hold_err, busy_bad, waits_total, req_cycles, post_act;
    bit timed_out, rst_req_low, rst_busy_low;

    // Reference model expectations
    logic [31:0] exp_addr_q[$], exp_wdata_q[$], exp_rfdata_q[$];
    logic [3:0]  exp_rfreg_q[$];
    int exp_cyc;

    ldm_stm_sequencer #(.ADDR_W(32), .REGS(16)) dut (
        .clock(clock), .reset(reset), .start(start), .is_load(is_load),
        .reg_list(reg_list), .base_reg(base_reg), .base_addr(base_addr),
        .up(up), .pre(pre), .writeback(writeback),
        .rf_read_num(rf_read_num), .rf_read_data(rf_read_data),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_regwrite(rf_regwrite), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .done(done)
    );

    assign rf_read_data = rf[rf_read_num];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C5A_0F96;
    endfunction

    // Expected transfers from the list/addressing rules, using the current rf contents.
    task automatic model(input logic ld, input logic [15:0] list, input logic [3:0] breg,
                         input logic [31:0] base, input logic u, input logic p, input logic w);
        int regs[$];
        logic [31:0] low, n4, a;
        exp_addr_q.delete(); exp_wdata_q.delete(); exp_rfreg_q.delete(); exp_rfdata_q.delete();
        for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(i);
        n4 = 32'(regs.size()) << 2;
        if (u) low = p ? base + 32'd4 : base;
        else   low = p ? base - n4 : base - n4 + 32'd4;
        for (int k = 0; k < regs.size(); k++) begin
            a = low + (32'(k) << 2);
            exp_addr_q.push_back(a);
            if (ld) begin
                exp_rfreg_q.push_back(4'(regs[k]));
                exp_rfdata_q.push_back(memval(a));
            end else begin
                exp_wdata_q.push_back(rf[regs[k]]);
            end
        end
        if (regs.size() > 0 && w && !(ld && list[breg])) begin
            exp_rfreg_q.push_back(breg);
            exp_rfdata_q.push_back(u ? base + n4 : base - n4);
        end
        exp_cyc = (regs.size() == 0) ? 2 : (ld ? 3 + 2 * regs.size() : 3 + regs.size());
    endtask

    // Issue one command and act as memory/register file until done (or reset at request rst_at).
    task automatic run_cmd(input logic ld, input logic [15:0] list, input logic [3:0] breg,
                           input logic [31:0] base, input logic u, input logic p, input logic w,
                           input int dly, input int rst_at);
        int wait_cnt, cur_dly, req_no;
        bit in_req;
        logic [31:0] h_addr, h_wdata;
        logic h_we;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        rfw_reg_q.delete(); rfw_data_q.delete();
        done_cyc = 0; hold_err = 0; busy_bad = 0; waits_total = 0; req_cycles = 0; post_act = 0;
        timed_out = 1; rst_req_low = 0; rst_busy_low = 0;
        in_req = 0; req_no = 0; wait_cnt = 0; cur_dly = 0;
        h_addr = '0; h_wdata = '0; h_we = 1'b0;
        @(negedge clock);
        is_load = ld; reg_list = list; base_reg = breg; base_addr = base;
        up = u; pre = p; writeback = w; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (done) begin
                done_cyc = cyc;
                if (busy !== 1'b0) busy_bad++;
                timed_out = 0;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (rf_regwrite) begin
                rfw_reg_q.push_back(rf_write_reg);
                rfw_data_q.push_back(rf_write_data);
                rf[rf_write_reg] = rf_write_data;
            end
            if (mem_req) begin
                req_cycles++;
                if (!in_req) begin
                    in_req = 1; req_no++; wait_cnt = 0;
                    cur_dly = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
                    h_addr = mem_addr; h_wdata = mem_wdata; h_we = mem_we;
                end else if (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_we !== h_we) begin
                    hold_err++;
                end
                if (rst_at == req_no) begin
                    reset = 1'b1;
                    #1;
                    rst_req_low = (mem_req === 1'b0);
                    rst_busy_low = (busy === 1'b0);
                    timed_out = 0;
                    repeat (2) begin
                        @(negedge clock);
                        if (rf_regwrite || mem_req || busy || done) post_act++;
                    end
                    reset = 1'b0;
                    repeat (3) begin
                        @(negedge clock);
                        if (rf_regwrite || mem_req || busy || done) post_act++;
                    end
                    break;
                end
                if (wait_cnt == cur_dly) begin
                    mem_ack = 1'b1;
                    if (h_we) begin
                        wr_addr_q.push_back(h_addr);
                        wr_data_q.push_back(h_wdata);
                    end else begin
                        rd_addr_q.push_back(h_addr);
                        mem_rdata = memval(h_addr);
                    end
                    waits_total += cur_dly;
                    in_req = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clock);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; is_load = 1'b1; reg_list = 16'hFFFF; base_reg = 4'd3;
        base_addr = 32'h1234_5678; up = 1'b1; pre = 1'b1; writeback = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({busy, done, mem_req, mem_we, rf_regwrite} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got busy/done/req/we/rfw=%b want 00000",
                     {busy, done, mem_req, mem_we, rf_regwrite});
        end
        vectors++;
        if ({mem_addr, mem_wdata, rf_write_data, rf_write_reg, rf_read_num} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got addr=%h wdata=%h rfwd=%h rfwr=%h rfrn=%h want all 0",
                     mem_addr, mem_wdata, rf_write_data, rf_write_reg, rf_read_num);
        end
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got busy=%b req=%b want 0 0", busy, mem_req);
        end
    endtask

    task automatic test_stm_ia();
        logic [31:0] ea[3], ed[3];
        ea = '{32'h1000, 32'h1004, 32'h1008};
        ed = '{32'h11, 32'h22, 32'h33};
        rf[0] = 32'h1000; rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        run_cmd(1'b0, 16'h000E, 4'd0, 32'h1000, 1'b1, 1'b0, 1'b1, 0, 0);
        vectors++;
        if (wr_addr_q.size() != 3 || rd_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL stm_ia_count got wr=%0d rd=%0d want 3 0", wr_addr_q.size(), rd_addr_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= wr_addr_q.size() || wr_addr_q[k] !== ea[k] || wr_data_q[k] !== ed[k]) begin
                miscompares++;
                $display("FAIL stm_ia_wr%0d got %h@%h want %h@%h", k, wr_data_q[k], wr_addr_q[k], ed[k], ea[k]);
            end
        end
        vectors++;
        if (rfw_reg_q.size() != 1 || rfw_reg_q[0] !== 4'd0 || rfw_data_q[0] !== 32'h100C) begin
            miscompares++;
            $display("FAIL stm_ia_wb got n=%0d R%0d=%h want 1 R0=0000100c",
                     rfw_reg_q.size(), rfw_reg_q[0], rfw_data_q[0]);
        end
        vectors++;
        if (done_cyc != 6 || timed_out) begin
            miscompares++;
            $display("FAIL stm_ia_cycles got %0d want 6", done_cyc);
        end
    endtask

    task automatic test_ldm_db();
        logic [31:0] ea[3], ewd[4];
        logic [3:0]  ewr[4];
        ea  = '{32'h1FF4, 32'h1FF8, 32'h1FFC};
        ewr = '{4'd0, 4'd1, 4'd15, 4'd13};
        ewd = '{memval(32'h1FF4), memval(32'h1FF8), memval(32'h1FFC), 32'h1FF4};
        run_cmd(1'b1, 16'h8003, 4'd13, 32'h2000, 1'b0, 1'b1, 1'b1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (k >= rd_addr_q.size() || rd_addr_q[k] !== ea[k]) begin
                miscompares++;
                $display("FAIL ldm_db_rd%0d got %h want %h", k, rd_addr_q[k], ea[k]);
            end
        end
        vectors++;
        if (rfw_reg_q.size() != 4 || wr_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL ldm_db_count got rfw=%0d wr=%0d want 4 0", rfw_reg_q.size(), wr_addr_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= rfw_reg_q.size() || rfw_reg_q[k] !== ewr[k] || rfw_data_q[k] !== ewd[k]) begin
                miscompares++;
                $display("FAIL ldm_db_rfw%0d got R%0d=%h want R%0d=%h", k, rfw_reg_q[k], rfw_data_q[k], ewr[k], ewd[k]);
            end
        end
        vectors++;
        if (done_cyc != 9) begin
            miscompares++;
            $display("FAIL ldm_db_cycles got %0d want 9", done_cyc);
        end
    endtask

    task automatic test_ldm_ib_base();
        run_cmd(1'b1, 16'h0006, 4'd2, 32'h100, 1'b1, 1'b1, 1'b1, 0, 0);
        vectors++;
        if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 32'h104 || rd_addr_q[1] !== 32'h108) begin
            miscompares++;
            $display("FAIL ldm_ib_rd got n=%0d %h %h want 2 00000104 00000108",
                     rd_addr_q.size(), rd_addr_q[0], rd_addr_q[1]);
        end
        vectors++;
        if (rfw_reg_q.size() != 2 || rfw_reg_q[0] !== 4'd1 || rfw_reg_q[1] !== 4'd2 ||
            rfw_data_q[1] !== memval(32'h108)) begin
            miscompares++;
            $display("FAIL ldm_ib_nowb got n=%0d last R%0d=%h want 2 R2=%h",
                     rfw_reg_q.size(), rfw_reg_q[1], rfw_data_q[1], memval(32'h108));
        end
        vectors++;
        if (busy_bad != 0 || done_cyc != 7) begin
            miscompares++;
            $display("FAIL ldm_ib_busy got bad=%0d cyc=%0d want 0 7", busy_bad, done_cyc);
        end
    endtask

    task automatic test_wait_states();
        rf[0] = 32'hDEAD_BEEF;
        run_cmd(1'b0, 16'h0001, 4'd5, 32'h40, 1'b0, 1'b0, 1'b0, 3, 0);
        vectors++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h40 || wr_data_q[0] !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL wait_wr got n=%0d %h@%h want 1 deadbeef@00000040",
                     wr_addr_q.size(), wr_data_q[0], wr_addr_q[0]);
        end
        vectors++;
        if (req_cycles != 4 || hold_err != 0) begin
            miscompares++;
            $display("FAIL wait_hold got req_cycles=%0d unstable=%0d want 4 0", req_cycles, hold_err);
        end
        vectors++;
        if (rfw_reg_q.size() != 0 || done_cyc != 7) begin
            miscompares++;
            $display("FAIL wait_nowb got rfw=%0d cyc=%0d want 0 7", rfw_reg_q.size(), done_cyc);
        end
    endtask

    task automatic test_empty_list();
        run_cmd(1'b1, 16'h0000, 4'd1, 32'h500, 1'b1, 1'b0, 1'b1, 0, 0);
        vectors++;
        if (req_cycles != 0 || rfw_reg_q.size() != 0 || done_cyc != 2) begin
            miscompares++;
            $display("FAIL empty got req=%0d rfw=%0d cyc=%0d want 0 0 2",
                     req_cycles, rfw_reg_q.size(), done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        run_cmd(1'b1, 16'h00F0, 4'd0, 32'h3000, 1'b1, 1'b0, 1'b1, 0, 2);
        vectors++;
        if (!rst_req_low || !rst_busy_low) begin
            miscompares++;
            $display("FAIL rst_mid_async got req_low=%0d busy_low=%0d want 1 1", rst_req_low, rst_busy_low);
        end
        vectors++;
        if (rfw_reg_q.size() != 1 || rfw_reg_q[0] !== 4'd4 || post_act != 0) begin
            miscompares++;
            $display("FAIL rst_mid_abandon got rfw=%0d after_reset=%0d want 1 0", rfw_reg_q.size(), post_act);
        end
        run_cmd(1'b1, 16'h00F0, 4'd0, 32'h3000, 1'b1, 1'b0, 1'b1, 0, 0);
        vectors++;
        if (done_cyc != 11 || rfw_reg_q.size() != 5 || rfw_data_q[4] !== 32'h3010) begin
            miscompares++;
            $display("FAIL rst_mid_restart got cyc=%0d rfw=%0d wb=%h want 11 5 00003010",
                     done_cyc, rfw_reg_q.size(), rfw_data_q[4]);
        end
    endtask

    task automatic test_random();
        logic ld, u, p, w;
        logic [15:0] list;
        logic [3:0] breg;
        logic [31:0] base;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 16; r++) rf[r] = $urandom;
            ld = 1'($urandom); u = 1'($urandom); p = 1'($urandom); w = 1'($urandom);
            list = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            breg = 4'($urandom);
            base = $urandom & 32'hFFFF_FFFC;
            if (it < 4) base = (it[0]) ? 32'h0000_0008 : 32'hFFFF_FFF8;
            model(ld, list, breg, base, u, p, w);
            run_cmd(ld, list, breg, base, u, p, w, -1, 0);
            vectors++;
            if (timed_out || done_cyc != exp_cyc + waits_total || hold_err != 0 || busy_bad != 0) begin
                miscompares++;
                $display("FAIL rand%0d_timing got cyc=%0d unstable=%0d busybad=%0d want cyc=%0d 0 0",
                         it, done_cyc, hold_err, busy_bad, exp_cyc + waits_total);
            end
            vectors++;
            if ((ld ? rd_addr_q.size() : wr_addr_q.size()) != exp_addr_q.size() ||
                (ld ? wr_addr_q.size() : rd_addr_q.size()) != 0) begin
                miscompares++;
                $display("FAIL rand%0d_nxfer got rd=%0d wr=%0d want %0d of %s",
                         it, rd_addr_q.size(), wr_addr_q.size(), exp_addr_q.size(), ld ? "reads" : "writes");
            end
            for (int k = 0; k < exp_addr_q.size(); k++) begin
                vectors++;
                if (ld ? (rd_addr_q[k] !== exp_addr_q[k])
                       : (wr_addr_q[k] !== exp_addr_q[k] || wr_data_q[k] !== exp_wdata_q[k])) begin
                    miscompares++;
                    $display("FAIL rand%0d_xfer%0d got addr=%h/%h data=%h want addr=%h data=%h", it, k,
                             rd_addr_q[k], wr_addr_q[k], wr_data_q[k], exp_addr_q[k],
                             ld ? 32'h0 : exp_wdata_q[k]);
                end
            end
            vectors++;
            if (rfw_reg_q.size() != exp_rfreg_q.size()) begin
                miscompares++;
                $display("FAIL rand%0d_nrfw got %0d want %0d", it, rfw_reg_q.size(), exp_rfreg_q.size());
            end
            for (int k = 0; k < exp_rfreg_q.size(); k++) begin
                vectors++;
                if (rfw_reg_q[k] !== exp_rfreg_q[k] || rfw_data_q[k] !== exp_rfdata_q[k]) begin
                    miscompares++;
                    $display("FAIL rand%0d_rfw%0d got R%0d=%h want R%0d=%h", it, k,
                             rfw_reg_q[k], rfw_data_q[k], exp_rfreg_q[k], exp_rfdata_q[k]);
                end
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = '0;
        test_reset();
        test_stm_ia();
        test_ldm_db();
        test_ldm_ib_base();
        test_wait_states();
        test_empty_list();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
Block-transfer initiator for LDM/STM instructions. It is the client side of the register file: it drives register numbers and read/write strobes into the register file port, and it runs the memory handshake. It walks a 16-bit register list one register per transfer, generates the word addresses for all four ARM addressing modes, and optionally writes back the base register. It sits between the decode stage and the register file / data memory interface.

Parameters:
ADDR_W, 32, memory address width and register data width
REGS, 16, number of architectural registers (list width; register number width is log2(REGS)=4)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin transfer; sampled only in IDLE
is_load  input  1  1 = LDM, 0 = STM
reg_list  input  16  bit i set = transfer register i
base_reg  input  4  base register number
base_addr  input  32  base register value, captured at start
up  input  1  U bit: 1 increment, 0 decrement
pre  input  1  P bit: 1 before, 0 after
writeback  input  1  W bit
rf_read_num  output  4  register file read select (STM data)
rf_read_data  input  32  register file read data
rf_write_reg  output  4  register file write select
rf_write_data  output  32  register file write data
rf_regwrite  output  1  register file write strobe
mem_req  output  1  memory request
mem_we  output  1  1 = write (STM)
mem_addr  output  32  word address, bits[1:0] always 0
mem_wdata  output  32  store data
mem_ack  input  1  memory accepts/completes the current request
mem_rdata  input  32  load data, valid with mem_ack
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous): state=IDLE. Every output is 0. A reset during a transfer abandons it immediately: mem_req drops with no further writes, and no writeback occurs.
- State sequence: IDLE -> SETUP -> (XFER [-> LOAD_WR])* -> WB -> DONE -> IDLE.
- IDLE: when start=1, latch all command inputs and go to SETUP. When start=0, remain in IDLE. start is ignored outside IDLE.
- SETUP (1 cycle):
  - N = popcount(reg_list).
  - Start address: IA (up=1, pre=0) = base; IB (up=1, pre=1) = base+4; DA (up=0, pre=0) = base-4N+4; DB (up=0, pre=1) = base-4N.
  - Final address: up ? base+4N : base-4N. All arithmetic is mod 2^32.
  - If N=0: go directly to DONE. There is no memory access and no writeback.
- XFER:
  - cur = lowest set bit of the remaining list. The lowest register always goes to the lowest address, in all modes.
  - Drive mem_req=1, mem_addr=current address, mem_we=~is_load.
  - STM: rf_read_num=cur and mem_wdata=rf_read_data, combinationally.
  - Hold all request signals stable until mem_ack=1. mem_ack in the same cycle the request first appears is legal.
  - On ack: clear bit cur and add 4 to the address.
  - LDM: capture mem_rdata and go to LOAD_WR.
  - STM: go to XFER if bits remain, else WB.
- LOAD_WR (1 cycle): rf_regwrite=1, rf_write_reg=cur, rf_write_data=captured data. Then go to XFER or WB. mem_req=0 in this state.
- WB (1 cycle): rf_regwrite=1 with rf_write_reg=base_reg and rf_write_data=final address, if and only if writeback=1 and not (is_load and reg_list[base_reg]). When a load includes the base register, the loaded value wins. Otherwise rf_regwrite=0.
- STM with base_reg in the list stores the base value as held in the register file; writeback only happens in WB, after all stores.
- DONE (1 cycle): done=1. busy=0 in the same cycle. Next state is IDLE, so a new start is accepted the cycle after done.
- busy=1 in SETUP, XFER, LOAD_WR and WB.
- Outputs outside their active states: rf_regwrite and mem_req are 0. Address and data outputs are don't-care but are driven 0.
- Cycle count with zero-wait memory (ack in the first XFER cycle): STM = 1+N+1+1, LDM = 1+2N+1+1, measured from the start edge to done inclusive.
- Register 15 is handled like any other register (no PC special-casing in this block).

Test Plan:
- STM IA: list=0x000E, base_reg=0, base=0x1000, W=1, R1..R3=0x11/0x22/0x33, ack same-cycle -> writes 0x11@0x1000, 0x22@0x1004, 0x33@0x1008; R0 written 0x100C; done on cycle 6.
- LDM DB: list=0x8003, base=0x2000, W=1, base_reg=13 -> reads 0x1FF4→R0, 0x1FF8→R1, 0x1FFC→R15; R13 written 0x1FF4.
- LDM IB with base in list: base_reg=2, list=0x0006, base=0x100, W=1 -> reads 0x104→R1, 0x108→R2; no WB write (R2 keeps loaded value); busy falls when done pulses.
- Wait states: STM DA list=0x0001, base=0x40, ack delayed 3 cycles -> mem_req/mem_addr=0x40/mem_wdata held stable for 4 cycles; single write, no WB (W=0).
- Empty list: list=0x0000, W=1 -> no mem_req, no rf_regwrite, done 2 cycles after start.
- Reset mid-transfer: assert reset during the 2nd XFER of a 4-register LDM -> mem_req and busy drop asynchronously; no further rf writes; a fresh start works normally.
